// File: rtl/pipe_regfile_sb.sv
// rtl/pipe_regfile_sb.sv - register file with write-through bypass and per-register pending-write scoreboard
// Optional feature macro: RF_SCOREBOARD_EN (scoreboard counters and stall logic).
module pipe_regfile_sb #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 2
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic [AW-1:0] rna,
    input  logic [AW-1:0] rnb,
    output logic [DW-1:0] qa,
    output logic [DW-1:0] qb,
    input  logic          iss_valid,
    input  logic          iss_wreg,
    input  logic [AW-1:0] iss_rn,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_rn,
    input  logic [DW-1:0] wb_d,
    output logic          stall,
    output logic          iss_ack
);

    localparam int NREG = 1 << AW;

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic          wb_live;

    assign wb_live = wb_we && (wb_rn != '0);

    always_comb begin
        regs_d = regs_q;
        if (wb_live) begin
            regs_d[wb_rn] = wb_d;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Write-through: an in-flight write-back is visible to ID in the same cycle.
    always_comb begin
        qa = '0;
        qb = '0;
        if (resetn && (rna != '0)) begin
            qa = (wb_live && (wb_rn == rna)) ? wb_d : regs_q[rna];
        end
        if (resetn && (rnb != '0)) begin
            qb = (wb_live && (wb_rn == rnb)) ? wb_d : regs_q[rnb];
        end
    end

`ifdef RF_SCOREBOARD_EN
    localparam logic [CW-1:0] PEND_MAX = '1;
    localparam logic [CW-1:0] PEND_ONE = CW'(1);

    logic [CW-1:0]   pend_q [NREG];
    logic [CW-1:0]   pend_d [NREG];
    logic [NREG-1:0] inc_v;
    logic [NREG-1:0] dec_v;
    logic            haz_a;
    logic            haz_b;
    logic            sat;

    // A source whose only outstanding write is arriving right now is satisfied by the bypass.
    assign haz_a = (rna != '0) && (pend_q[rna] != '0) &&
                   !((pend_q[rna] == PEND_ONE) && wb_we && (wb_rn == rna));
    assign haz_b = (rnb != '0) && (pend_q[rnb] != '0) &&
                   !((pend_q[rnb] == PEND_ONE) && wb_we && (wb_rn == rnb));
    assign sat   = iss_wreg && (iss_rn != '0) && (pend_q[iss_rn] == PEND_MAX) &&
                   !(wb_we && (wb_rn == iss_rn));

    assign stall   = resetn && iss_valid && (haz_a || haz_b || sat);
    assign iss_ack = resetn && iss_valid && !stall;

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_v[r] = iss_ack && iss_wreg && (iss_rn == AW'(r));
            dec_v[r] = wb_we && (wb_rn == AW'(r)) && (pend_q[r] != '0);
        end
    end

    always_comb begin
        pend_d = pend_q;
        for (int r = 1; r < NREG; r++) begin
            if (inc_v[r] && !dec_v[r]) begin
                pend_d[r] = pend_q[r] + PEND_ONE;
            end else if (dec_v[r] && !inc_v[r]) begin
                pend_d[r] = pend_q[r] - PEND_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
        end
    end
`else
    logic unused_iss;

    assign unused_iss = ^{iss_wreg, iss_rn};
    assign stall      = 1'b0;
    assign iss_ack    = resetn && iss_valid;
`endif

endmodule

// File: tb/tb_pipe_regfile_sb.sv
// tb/tb_pipe_regfile_sb.sv - self-checking bench for pipe_regfile_sb (stall expectations follow RF_SCOREBOARD_EN)
module tb_pipe_regfile_sb;

    logic        clock;
    logic        resetn;
    logic [4:0]  rna, rnb, iss_rn, wb_rn;
    logic [31:0] qa, qb, wb_d;
    logic        iss_valid, iss_wreg, wb_we, stall, iss_ack;

    pipe_regfile_sb #(.DW(32), .AW(5), .CW(2)) dut (
        .clock(clock), .resetn(resetn), .rna(rna), .rnb(rnb), .qa(qa), .qb(qb),
        .iss_valid(iss_valid), .iss_wreg(iss_wreg), .iss_rn(iss_rn),
        .wb_we(wb_we), .wb_rn(wb_rn), .wb_d(wb_d), .stall(stall), .iss_ack(iss_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        iv;
        logic        iw;
        logic [4:0]  irn;
        logic        we;
        logic [4:0]  wrn;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] eqa;
        logic [31:0] eqb;
        logic        est;
    } vec_t;

    typedef struct {
        logic [31:0] qa;
        logic [31:0] qb;
        logic        st;
        logic        ack;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    function automatic vec_t mk(input logic rst, input logic iv, input logic iw, input logic [4:0] irn,
                                input logic we, input logic [4:0] wrn, input logic [31:0] wd,
                                input logic [4:0] ra, input logic [4:0] rb,
                                input logic [31:0] eqa, input logic [31:0] eqb, input logic est);
        vec_t v;
        v.rst = rst; v.iv = iv; v.iw = iw; v.irn = irn; v.we = we; v.wrn = wrn; v.wd = wd;
        v.ra = ra; v.rb = rb; v.eqa = eqa; v.eqb = eqb; v.est = est;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    endtask

    initial begin
        exp_t e;
        logic sb_on;
`ifdef RF_SCOREBOARD_EN
        sb_on = 1'b1;
`else
        sb_on = 1'b0;
`endif
        resetn = 1'b0; iss_valid = 0; iss_wreg = 0; iss_rn = 0;
        wb_we = 0; wb_rn = 0; wb_d = 0; rna = 0; rnb = 0;

        //               rst iv iw irn we wrn wd            ra  rb  eqa           eqb           est
        vecs.push_back(mk(0, 1, 1, 3,  1, 5,  32'hAAAA,     5,  5,  0,            0,            0));
        vecs.push_back(mk(1, 0, 0, 0,  1, 5,  32'h1234,     0,  5,  0,            32'h1234,     0));
        vecs.push_back(mk(1, 0, 0, 0,  1, 0,  32'hFFFF,     0,  5,  0,            32'h1234,     0));
        vecs.push_back(mk(1, 0, 0, 0,  0, 0,  0,            5,  0,  32'h1234,     0,            0));
        vecs.push_back(mk(1, 0, 0, 0,  1, 7,  32'hDEAD,     5,  7,  32'h1234,     32'hDEAD,     0));
        vecs.push_back(mk(1, 0, 0, 0,  0, 0,  0,            7,  7,  32'hDEAD,     32'hDEAD,     0));
        // issue r3, then consumer waits for its write-back
        vecs.push_back(mk(1, 1, 1, 3,  0, 0,  0,            0,  0,  0,            0,            0));
        vecs.push_back(mk(1, 1, 0, 3,  0, 0,  0,            3,  0,  0,            0,            1));
        vecs.push_back(mk(1, 1, 0, 3,  0, 0,  0,            3,  0,  0,            0,            1));
        vecs.push_back(mk(1, 1, 0, 3,  1, 3,  32'h33,       3,  0,  32'h33,       0,            0));
        vecs.push_back(mk(1, 1, 0, 3,  0, 0,  0,            3,  0,  32'h33,       0,            0));
        vecs.push_back(mk(1, 1, 1, 8,  0, 0,  0,            0,  0,  0,            0,            0));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0,            0,  8,  0,            0,            1));
        vecs.push_back(mk(1, 0, 0, 0,  0, 0,  0,            0,  8,  0,            0,            0));
        vecs.push_back(mk(1, 0, 0, 0,  1, 8,  32'h88,       0,  8,  0,            32'h88,       0));
        // r4 saturation at 3 outstanding writes
        vecs.push_back(mk(1, 1, 1, 4,  0, 0,  0,            0,  0,  0,            0,            0));
        vecs.push_back(mk(1, 1, 1, 4,  0, 0,  0,            0,  0,  0,            0,            0));
        vecs.push_back(mk(1, 1, 1, 4,  0, 0,  0,            0,  0,  0,            0,            0));
        vecs.push_back(mk(1, 1, 1, 4,  0, 0,  0,            0,  0,  0,            0,            1));
        vecs.push_back(mk(1, 1, 1, 4,  1, 4,  32'h44,       0,  0,  0,            0,            0));
        vecs.push_back(mk(1, 1, 1, 4,  0, 0,  0,            0,  0,  0,            0,            1));
        vecs.push_back(mk(1, 0, 0, 0,  1, 4,  32'h45,       4,  0,  32'h45,       0,            0));
        vecs.push_back(mk(1, 0, 0, 0,  1, 4,  32'h45,       4,  0,  32'h45,       0,            0));
        vecs.push_back(mk(1, 0, 0, 0,  1, 4,  32'h45,       4,  0,  32'h45,       0,            0));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0,            4,  0,  32'h45,       0,            0));
        // write-back with nothing pending must not wrap the counter
        vecs.push_back(mk(1, 0, 0, 0,  1, 4,  32'h46,       0,  0,  0,            0,            0));
        vecs.push_back(mk(1, 1, 1, 4,  0, 0,  0,            0,  0,  0,            0,            0));
        vecs.push_back(mk(1, 1, 0, 0,  1, 4,  32'h47,       4,  0,  32'h47,       0,            0));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0,            4,  0,  32'h47,       0,            0));
        // r9: simultaneous issue and write-back keeps pend at 1
        vecs.push_back(mk(1, 1, 1, 9,  0, 0,  0,            0,  0,  0,            0,            0));
        vecs.push_back(mk(1, 1, 1, 9,  1, 9,  32'h99,       0,  0,  0,            0,            0));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0,            9,  0,  32'h99,       0,            1));
        vecs.push_back(mk(1, 1, 0, 0,  1, 9,  32'h9A,       9,  0,  32'h9A,       0,            0));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0,            9,  0,  32'h9A,       0,            0));
        // reset mid-sequence discards pending state and data
        vecs.push_back(mk(1, 1, 1, 10, 0, 0,  0,            0,  0,  0,            0,            0));
        vecs.push_back(mk(1, 1, 1, 11, 0, 0,  0,            0,  0,  0,            0,            0));
        vecs.push_back(mk(0, 1, 0, 0,  0, 0,  0,            10, 5,  0,            0,            0));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0,            10, 11, 0,            0,            0));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0,            9,  5,  0,            0,            0));
        vecs.push_back(mk(1, 0, 0, 0,  1, 10, 32'hA0,       0,  0,  0,            0,            0));
        vecs.push_back(mk(1, 1, 0, 0,  0, 0,  0,            10, 0,  32'hA0,       0,            0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clock);
            #1;
            resetn = vecs[i].rst; iss_valid = vecs[i].iv; iss_wreg = vecs[i].iw; iss_rn = vecs[i].irn;
            wb_we = vecs[i].we; wb_rn = vecs[i].wrn; wb_d = vecs[i].wd; rna = vecs[i].ra; rnb = vecs[i].rb;
            e.qa  = vecs[i].eqa;
            e.qb  = vecs[i].eqb;
            e.st  = sb_on & vecs[i].est;
            e.ack = vecs[i].rst & vecs[i].iv & ~e.st;
            exp_q.push_back(e);
            @(negedge clock);
            e = exp_q.pop_front();
            chk("qa", i, qa, e.qa);
            chk("qb", i, qb, e.qb);
            chk("stall", i, {31'b0, stall}, {31'b0, e.st});
            chk("iss_ack", i, {31'b0, iss_ack}, {31'b0, e.ack});
        end

        // asynchronous reset pulse between edges
        @(posedge clock);
        #1;
        resetn = 1'b1; iss_valid = 1'b1; iss_wreg = 1'b1; iss_rn = 5'd12;
        wb_we = 1'b0; wb_rn = 0; wb_d = 0; rna = 5'd10; rnb = 5'd0;
        #1 chk("async_pre_qa", 100, qa, 32'hA0);
        chk("async_pre_ack", 100, {31'b0, iss_ack}, 32'd1);
        @(posedge clock);
        #1;
        iss_wreg = 1'b0; iss_rn = 0; rna = 5'd10; rnb = 5'd12;
        chk("pend_r12_stall", 101, {31'b0, stall}, {31'b0, sb_on});
        #1 resetn = 1'b0;
        #1;
        chk("async_qa", 101, qa, 32'h0);
        chk("async_stall", 101, {31'b0, stall}, 32'd0);
        chk("async_ack", 101, {31'b0, iss_ack}, 32'd0);
        #1 resetn = 1'b1;
        @(negedge clock);
        chk("post_rst_qa", 102, qa, 32'h0);
        chk("post_rst_stall", 102, {31'b0, stall}, 32'd0);
        chk("post_rst_ack", 102, {31'b0, iss_ack}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
